// File: rtl/dma_burst_planner_if.sv
// Burst command channel between dma_burst_planner (master) and the AHB-Lite master (slave).
// The slave side reports completion or error of each issued burst.
interface dma_burst_planner_if;
   logic        o_cmd_valid;
   logic        i_cmd_ready;
   logic [31:0] o_cmd_addr;
   logic [2:0]  o_cmd_hburst;
   logic [4:0]  o_cmd_beats;
   logic        i_burst_done;
   logic        i_burst_err;

   modport master (
      output o_cmd_valid, o_cmd_addr, o_cmd_hburst, o_cmd_beats,
      input  i_cmd_ready, i_burst_done, i_burst_err
   );

   modport slave (
      input  o_cmd_valid, o_cmd_addr, o_cmd_hburst, o_cmd_beats,
      output i_cmd_ready, i_burst_done, i_burst_err
   );
endinterface

// File: rtl/dma_burst_planner.sv
// Splits a DMA job into AHB INCR16/INCR8/INCR4/SINGLE bursts that stay inside 1 KB pages
// and fit the write FIFO's free space; issues them one at a time and pulses Master_Done.
module dma_burst_planner #(
   parameter int unsigned FIFO_DEPTH = 32,
   parameter int unsigned MAX_BEATS  = 16
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic                       NewCommandOn,
   input  logic [15:0]                i_RCC_DMA_ADDR_HIGH,
   input  logic [15:0]                i_RCC_DMA_ADDR_LOW,
   input  logic [5:0]                 i_RCC_BUFFER_LENGTH,
   input  logic [5:0]                 i_FIFO_data_count,
   dma_burst_planner_if.master        cmd,
   output logic                       o_busy,
   output logic                       Master_Done,
   output logic                       o_error
);

   typedef enum logic [2:0] {StIdle, StPlan, StIssue, StWait, StFinish} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [5:0]  rem_q, rem_d;
   logic        err_q, err_d;
   logic [31:0] cmd_addr_q, cmd_addr_d;
   logic [2:0]  hburst_q, hburst_d;
   logic [4:0]  beats_q, beats_d;

   logic [8:0]  bnd_words;
   logic [31:0] fifo_free;
   logic [31:0] limit;
   logic [4:0]  plan_beats;
   logic [2:0]  plan_hburst;

   // Largest legal burst: min of MAX_BEATS, remaining words, words to the 1 KB page
   // end and FIFO free space, rounded down to 16/8/4/1. Zero means stall.
   always_comb begin
      bnd_words   = 9'd256 - {1'b0, addr_q[9:2]};
      fifo_free   = (32'(i_FIFO_data_count) >= FIFO_DEPTH) ? 32'd0
                                                            : FIFO_DEPTH - 32'(i_FIFO_data_count);
      limit       = MAX_BEATS;
      if (32'(rem_q) < limit)     limit = 32'(rem_q);
      if (32'(bnd_words) < limit) limit = 32'(bnd_words);
      if (fifo_free < limit)      limit = fifo_free;
      plan_beats  = 5'd0;
      plan_hburst = 3'b000;
      if (limit >= 32'd16) begin
         plan_beats  = 5'd16;
         plan_hburst = 3'b111;
      end else if (limit >= 32'd8) begin
         plan_beats  = 5'd8;
         plan_hburst = 3'b101;
      end else if (limit >= 32'd4) begin
         plan_beats  = 5'd4;
         plan_hburst = 3'b011;
      end else if (limit >= 32'd1) begin
         plan_beats  = 5'd1;
         plan_hburst = 3'b000;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      err_d      = err_q;
      cmd_addr_d = cmd_addr_q;
      hburst_d   = hburst_q;
      beats_d    = beats_q;
      unique case (state_q)
         StIdle: begin
            if (NewCommandOn) begin
               addr_d  = {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW[15:2], 2'b00};
               rem_d   = i_RCC_BUFFER_LENGTH;
               err_d   = (i_RCC_DMA_ADDR_LOW[1:0] != 2'b00);
               state_d = StPlan;
            end
         end
         StPlan: begin
            if (rem_q == 6'd0) begin
               state_d = StFinish;
            end else if (plan_beats != 5'd0) begin
               cmd_addr_d = addr_q;
               hburst_d   = plan_hburst;
               beats_d    = plan_beats;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            if (cmd.i_cmd_ready) begin
               addr_d  = addr_q + {25'd0, beats_q, 2'b00};
               rem_d   = rem_q - {1'b0, beats_q};
               state_d = StWait;
            end
         end
         StWait: begin
            // Error takes priority over a coincident done; the rest of the job is dropped.
            if (cmd.i_burst_err) begin
               err_d   = 1'b1;
               state_d = StFinish;
            end else if (cmd.i_burst_done) begin
               state_d = (rem_q != 6'd0) ? StPlan : StFinish;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= StIdle;
         addr_q     <= 32'd0;
         rem_q      <= 6'd0;
         err_q      <= 1'b0;
         cmd_addr_q <= 32'd0;
         hburst_q   <= 3'b000;
         beats_q    <= 5'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         err_q      <= err_d;
         cmd_addr_q <= cmd_addr_d;
         hburst_q   <= hburst_d;
         beats_q    <= beats_d;
      end
   end

   assign cmd.o_cmd_valid  = (state_q == StIssue);
   assign cmd.o_cmd_addr   = cmd_addr_q;
   assign cmd.o_cmd_hburst = hburst_q;
   assign cmd.o_cmd_beats  = beats_q;
   assign o_busy           = (state_q != StIdle);
   assign Master_Done      = (state_q == StFinish);
   assign o_error          = err_q;

endmodule

// File: tb/tb_dma_burst_planner.sv
// Directed plus randomized bench for dma_burst_planner; expected bursts come from a
// page/FIFO arithmetic model of the job, not from the design's state machine.
module tb_dma_burst_planner;
   localparam int unsigned FIFO_DEPTH = 32;
   localparam int unsigned MAX_BEATS  = 16;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        NewCommandOn = 1'b0;
   logic [15:0] addr_hi = 16'd0;
   logic [15:0] addr_lo = 16'd0;
   logic [5:0]  buf_len = 6'd0;
   logic [5:0]  fifo_cnt = 6'd0;
   logic        o_busy;
   logic        Master_Done;
   logic        o_error;

   dma_burst_planner_if bus ();

   dma_burst_planner #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .MAX_BEATS  (MAX_BEATS)
   ) dut (
      .HCLK                (HCLK),
      .HRESETn             (HRESETn),
      .NewCommandOn        (NewCommandOn),
      .i_RCC_DMA_ADDR_HIGH (addr_hi),
      .i_RCC_DMA_ADDR_LOW  (addr_lo),
      .i_RCC_BUFFER_LENGTH (buf_len),
      .i_FIFO_data_count   (fifo_cnt),
      .cmd                 (bus),
      .o_busy              (o_busy),
      .Master_Done         (Master_Done),
      .o_error             (o_error)
   );

   always #5 HCLK = ~HCLK;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [31:0] exp_addr[$];
   int          exp_beats[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] hburst_of(input int n);
      case (n)
         16:      return 3'b111;
         8:       return 3'b101;
         4:       return 3'b011;
         default: return 3'b000;
      endcase
   endfunction

   // Reference: walk the job, taking the biggest of 16/8/4 that fits in every limit, else 1.
   function automatic void build_model(input logic [31:0] a, input int len, input int fcnt);
      logic [31:0] cur;
      int          rem;
      int          f;
      int          b;
      int          n;
      int          sizes[3];
      sizes = '{16, 8, 4};
      cur = a & 32'hFFFF_FFFC;
      rem = len;
      f   = int'(FIFO_DEPTH) - fcnt;
      exp_addr.delete();
      exp_beats.delete();
      while (rem > 0) begin
         b = (1024 - int'(cur % 32'd1024)) / 4;
         n = 1;
         for (int k = 0; k < 3; k++) begin
            if (sizes[k] <= int'(MAX_BEATS) && sizes[k] <= rem && sizes[k] <= b &&
                sizes[k] <= f) begin
               n = sizes[k];
               break;
            end
         end
         exp_addr.push_back(cur);
         exp_beats.push_back(n);
         cur = cur + 32'(4 * n);
         rem = rem - n;
      end
   endfunction

   task automatic start_job(input logic [31:0] a, input int len, input int fcnt);
      @(negedge HCLK);
      addr_hi      = a[31:16];
      addr_lo      = a[15:0];
      buf_len      = len[5:0];
      fifo_cnt     = fcnt[5:0];
      NewCommandOn = 1'b1;
   endtask

   // err_at: index of the burst answered with an error (-1 for none).
   task automatic run_job(input logic [31:0] a, input int len, input int fcnt,
                          input int err_at, input bit noise);
      logic exp_err;
      int   cyc;
      int   nb;
      bit   ended;
      build_model(a, len, fcnt);
      exp_err = (a[1:0] != 2'b00);
      nb      = exp_addr.size();
      ended   = 1'b0;
      start_job(a, len, fcnt);
      if (nb == 0) begin
         @(negedge HCLK);
         NewCommandOn = 1'b0;
         check("len0_busy", o_busy, 1);
         @(negedge HCLK);
         check("len0_done", Master_Done, 1);
         check("len0_no_cmd", bus.o_cmd_valid, 0);
      end
      for (int i = 0; i < nb && !ended; i++) begin
         cyc = 0;
         do begin
            @(negedge HCLK);
            NewCommandOn     = 1'b0;
            bus.i_burst_done = 1'b0;
            bus.i_burst_err  = 1'b0;
            cyc++;
         end while (!bus.o_cmd_valid && cyc < 60);
         check("cmd_latency", cyc, 2);
         if (!bus.o_cmd_valid) return;
         check("cmd_addr", bus.o_cmd_addr, exp_addr[i]);
         check("cmd_beats", bus.o_cmd_beats, exp_beats[i]);
         check("cmd_hburst", bus.o_cmd_hburst, hburst_of(exp_beats[i]));
         if (i == 0) check("err_at_latch", o_error, exp_err);
         repeat ($urandom_range(0, 2)) begin
            @(negedge HCLK);
            check("valid_hold", {bus.o_cmd_valid, bus.o_cmd_addr[30:0]},
                  {1'b1, exp_addr[i][30:0]});
         end
         bus.i_cmd_ready = 1'b1;
         @(negedge HCLK);
         bus.i_cmd_ready = 1'b0;
         check("valid_drop", bus.o_cmd_valid, 0);
         repeat ($urandom_range(0, 3)) begin
            if (noise) begin
               NewCommandOn = 1'b1;
               addr_hi      = 16'($urandom);
               buf_len      = 6'($urandom);
            end
            @(negedge HCLK);
            NewCommandOn = 1'b0;
         end
         if (i == err_at) begin
            bus.i_burst_err  = 1'b1;
            bus.i_burst_done = 1'($urandom_range(0, 1));
            @(negedge HCLK);
            bus.i_burst_err  = 1'b0;
            bus.i_burst_done = 1'b0;
            check("err_done_pulse", Master_Done, 1);
            check("err_flag", o_error, 1);
            exp_err = 1'b1;
            ended   = 1'b1;
         end else begin
            bus.i_burst_done = 1'b1;
            if (i == nb - 1) begin
               @(negedge HCLK);
               bus.i_burst_done = 1'b0;
               check("done_pulse", Master_Done, 1);
            end
         end
      end
      @(negedge HCLK);
      check("done_once", Master_Done, 0);
      check("idle_busy", o_busy, 0);
      check("idle_no_cmd", bus.o_cmd_valid, 0);
      check("job_error", o_error, exp_err);
   endtask

   // FIFO full at PLAN: nothing issued until space appears, then INCR8 on the next cycle.
   task automatic fifo_stall();
      bit seen;
      start_job(32'h0000_0000, 8, 32);
      @(negedge HCLK);
      NewCommandOn = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge HCLK);
         if (bus.o_cmd_valid) seen = 1'b1;
      end
      check("stall_no_valid", seen, 0);
      check("stall_busy", o_busy, 1);
      fifo_cnt = 6'd24;
      @(negedge HCLK);
      check("stall_release", bus.o_cmd_valid, 1);
      check("stall_beats", bus.o_cmd_beats, 8);
      check("stall_hburst", bus.o_cmd_hburst, 3'b101);
      bus.i_cmd_ready = 1'b1;
      @(negedge HCLK);
      bus.i_cmd_ready  = 1'b0;
      bus.i_burst_done = 1'b1;
      @(negedge HCLK);
      bus.i_burst_done = 1'b0;
      check("stall_done", Master_Done, 1);
      @(negedge HCLK);
      check("stall_idle", o_busy, 0);
   endtask

   task automatic reset_mid_job();
      int  cyc;
      bit  seen;
      start_job(32'h0000_0202, 40, 0);
      cyc = 0;
      do begin
         @(negedge HCLK);
         NewCommandOn = 1'b0;
         cyc++;
      end while (!bus.o_cmd_valid && cyc < 60);
      check("rst_cmd_seen", bus.o_cmd_valid, 1);
      bus.i_cmd_ready = 1'b1;
      @(negedge HCLK);
      bus.i_cmd_ready = 1'b0;
      check("rst_pre_error", o_error, 1);
      HRESETn = 1'b0;
      #1;
      check("rst_outputs", {bus.o_cmd_valid, o_busy, Master_Done, o_error}, 4'b0000);
      check("rst_cmd_addr", bus.o_cmd_addr, 0);
      check("rst_cmd_fields", {bus.o_cmd_hburst, bus.o_cmd_beats}, 0);
      @(negedge HCLK);
      HRESETn          = 1'b1;
      bus.i_burst_done = 1'b1;
      seen             = 1'b0;
      repeat (4) begin
         @(negedge HCLK);
         bus.i_burst_done = 1'b0;
         if (Master_Done || o_busy) seen = 1'b1;
      end
      check("rst_no_done", seen, 0);
   endtask

   initial begin
      logic [31:0] a;
      int          err_at;
      bus.i_cmd_ready  = 1'b0;
      bus.i_burst_done = 1'b0;
      bus.i_burst_err  = 1'b0;
      #2 HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      check("reset_outputs", {bus.o_cmd_valid, o_busy, Master_Done, o_error}, 4'b0000);
      check("reset_cmd_addr", bus.o_cmd_addr, 0);
      HRESETn = 1'b1;

      run_job(32'h0000_0000, 40, 0, -1, 1'b0);
      run_job(32'h0000_03F0, 8, 0, -1, 1'b0);
      run_job(32'h0000_0100, 3, 0, -1, 1'b0);
      fifo_stall();
      run_job(32'h0000_0000, 40, 0, 1, 1'b0);
      run_job(32'h1234_5678, 0, 0, -1, 1'b0);
      run_job(32'h0000_0102, 5, 0, -1, 1'b0);
      run_job(32'hFFFF_FFC0, 40, 0, -1, 1'b1);
      run_job(32'h0000_0800, 20, 27, -1, 1'b0);
      reset_mid_job();

      for (int j = 0; j < 25; j++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1) a[9:6] = 4'hF;
         err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         run_job(a, int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), err_at,
                 1'($urandom_range(0, 1)));
      end

      @(negedge HCLK);
      bus.i_cmd_ready  = 1'b1;
      bus.i_burst_done = 1'b1;
      @(negedge HCLK);
      bus.i_cmd_ready  = 1'b0;
      bus.i_burst_done = 1'b0;
      check("idle_ignores_inputs", {bus.o_cmd_valid, o_busy, Master_Done}, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
